// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing constants for the four-way button conditioner.
// Channel indices follow the bit order of the held output: {right,left,down,up}.
package button_conditioner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HOLD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_RELEASE_DB = 3'd4
    } btn_state_t;

    localparam int unsigned DB_COUNT_DEF   = 250000;
    localparam int unsigned RPT_DELAY_DEF  = 25000000;
    localparam int unsigned RPT_PERIOD_DEF = 5000000;
    localparam int unsigned CNT_W_DEF      = 26;

    localparam int N_CH     = 4;
    localparam int CH_UP    = 0;
    localparam int CH_DOWN  = 1;
    localparam int CH_LEFT  = 2;
    localparam int CH_RIGHT = 3;

    // A button counts as held from the accepted press until its release is debounced.
    function automatic logic is_held(btn_state_t s);
        return (s == ST_HOLD) || (s == ST_REPEAT) || (s == ST_RELEASE_DB);
    endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: two-flop synchronizer, debounce/auto-repeat FSM and its counter.
// pulse_req and held_next are combinational; the parent registers them.
//
// state         | meaning
// ------------- | ---------------------------------------------------------
// ST_IDLE       | button released and debounced
// ST_PRESS_DB   | synced high, waiting for DB_COUNT stable cycles
// ST_HOLD       | press accepted, counting toward the first auto-repeat
// ST_REPEAT     | auto-repeating every RPT_PERIOD cycles
// ST_RELEASE_DB | synced low, waiting for DB_COUNT stable cycles
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DB_COUNT   = DB_COUNT_DEF,
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse_req,
    output logic held_next
);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(RPT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [1:0]       sync_q;
    logic             synced;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             from_rpt_q, from_rpt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign synced  = sync_q[1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            from_rpt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            from_rpt_q <= from_rpt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        from_rpt_d = from_rpt_q;
        pulse_req  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (synced) begin
                    state_d = ST_PRESS_DB;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!synced) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    pulse_req = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HOLD: begin
                if (!synced) begin
                    // The first low sample already counts toward the release debounce.
                    state_d    = ST_RELEASE_DB;
                    cnt_d      = CNT_W'(1);
                    from_rpt_d = 1'b0;
                end else if (cnt_q >= DELAY_LAST) begin
                    state_d   = ST_REPEAT;
                    cnt_d     = '0;
                    pulse_req = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REPEAT: begin
                if (!synced) begin
                    state_d    = ST_RELEASE_DB;
                    cnt_d      = CNT_W'(1);
                    from_rpt_d = 1'b1;
                end else if (cnt_q >= PERIOD_LAST) begin
                    cnt_d     = '0;
                    pulse_req = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE_DB: begin
                if (synced) begin
                    state_d = from_rpt_q ? ST_REPEAT : ST_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign held_next = is_held(state_d);

endmodule

// File: rtl/button_conditioner.sv
// Four debounced push-button channels with auto-repeat and opposing-pair suppression.
// Pulses and held levels are registered here so all outputs come straight from flops.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DB_COUNT   = DB_COUNT_DEF,
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [3:0] held
);

    logic [N_CH-1:0] raw_vec;
    logic [N_CH-1:0] req_vec;
    logic [N_CH-1:0] held_next_vec;
    logic [N_CH-1:0] pulse_d;
    logic [N_CH-1:0] pulse_q;
    logic [N_CH-1:0] held_q;

    assign raw_vec = {btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DB_COUNT  (DB_COUNT),
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .raw      (raw_vec[i]),
            .pulse_req(req_vec[i]),
            .held_next(held_next_vec[i])
        );
    end

    // Contradictory commands in one cycle are dropped rather than arbitrated.
    always_comb begin
        pulse_d = req_vec;
        if (req_vec[CH_UP] && req_vec[CH_DOWN]) begin
            pulse_d[CH_UP]   = 1'b0;
            pulse_d[CH_DOWN] = 1'b0;
        end
        if (req_vec[CH_LEFT] && req_vec[CH_RIGHT]) begin
            pulse_d[CH_LEFT]  = 1'b0;
            pulse_d[CH_RIGHT] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_q <= '0;
            held_q  <= '0;
        end else begin
            pulse_q <= pulse_d;
            held_q  <= held_next_vec;
        end
    end

    assign up    = pulse_q[CH_UP];
    assign down  = pulse_q[CH_DOWN];
    assign left  = pulse_q[CH_LEFT];
    assign right = pulse_q[CH_RIGHT];
    assign held  = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short timing (DB=4, delay=10, period=3).
// Expected pulse cycles are queued when buttons are driven and popped as cycles elapse.
module tb_button_conditioner;

    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       up, down, left, right;
    logic [3:0] held;

    typedef struct {
        int         cyc;
        logic [3:0] pulses;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    button_conditioner #(
        .DB_COUNT  (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP),
        .CNT_W     (26)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .held     (held)
    );

    always #5 clk = ~clk;

    task automatic push(input int c, input logic [3:0] p);
        exp_t e;
        e.cyc    = c;
        e.pulses = p;
        sb.push_back(e);
    endtask

    // One clock; the scoreboard entry due this cycle is popped and compared.
    task automatic advance();
        logic [3:0] exp_p;
        logic [3:0] obs_p;
        exp_t       e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        exp_p = 4'b0000;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL sb_stale: entry for cycle %0d never compared, now cycle %0d", e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e     = sb.pop_front();
            exp_p = e.pulses;
        end
        obs_p = {right, left, down, up};
        checks++;
        if (obs_p !== exp_p) begin
            failures++;
            $display("FAIL pulses@%0d: got %b expected %b", cyc, obs_p, exp_p);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) advance();
    endtask

    task automatic test_reset();
        int base;
        btn_right = 1'b1;
        repeat (4) advance();
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held: got %b expected 0000", held);
        end
        checks++;
        if ({right, left, down, up} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses: got %b expected 0000", {right, left, down, up});
        end
        rst  = 1'b1;
        base = cyc;
        push(base + 7, 4'b1000);
        wait_to(base + 6);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held_early: got %b expected 0000", held);
        end
        wait_to(base + 7);
        checks++;
        if (held !== 4'b1000) begin
            failures++;
            $display("FAIL reset_held_press: got %b expected 1000", held);
        end
        btn_right = 1'b0;
        wait_to(base + 16);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held_release: got %b expected 0000", held);
        end
    endtask

    task automatic test_press_repeat();
        int base;
        base   = cyc;
        btn_up = 1'b1;
        push(base + 7, 4'b0001);
        push(base + 17, 4'b0001);
        push(base + 20, 4'b0001);
        wait_to(base + 6);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL press_held_early: got %b expected 0000", held);
        end
        wait_to(base + 7);
        checks++;
        if (held !== 4'b0001) begin
            failures++;
            $display("FAIL press_held: got %b expected 0001", held);
        end
        wait_to(base + 20);
        btn_up = 1'b0;
        wait_to(base + 25);
        checks++;
        if (held !== 4'b0001) begin
            failures++;
            $display("FAIL press_held_release_db: got %b expected 0001", held);
        end
        wait_to(base + 26);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL press_held_cleared: got %b expected 0000", held);
        end
        wait_to(base + 30);
    endtask

    task automatic test_glitch();
        int base;
        base     = cyc;
        btn_down = 1'b1;
        wait_to(base + 3);
        btn_down = 1'b0;
        for (int k = 4; k <= 10; k++) begin
            wait_to(base + k);
            checks++;
            if (held !== 4'b0000) begin
                failures++;
                $display("FAIL glitch3_held@%0d: got %b expected 0000", k, held);
            end
        end
        base     = cyc;
        btn_down = 1'b1;
        wait_to(base + 4);
        btn_down = 1'b0;
        wait_to(base + 10);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL glitch4_held: got %b expected 0000", held);
        end
        base     = cyc;
        btn_down = 1'b1;
        push(base + 7, 4'b0010);
        wait_to(base + 5);
        btn_down = 1'b0;
        wait_to(base + 7);
        checks++;
        if (held !== 4'b0010) begin
            failures++;
            $display("FAIL glitch5_held: got %b expected 0010", held);
        end
        wait_to(base + 10);
        checks++;
        if (held !== 4'b0010) begin
            failures++;
            $display("FAIL glitch5_held_db: got %b expected 0010", held);
        end
        wait_to(base + 11);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL glitch5_held_clear: got %b expected 0000", held);
        end
        wait_to(base + 14);
    endtask

    task automatic test_opposing();
        int base;
        base      = cyc;
        btn_left  = 1'b1;
        btn_right = 1'b1;
        wait_to(base + 6);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL opp_held_early: got %b expected 0000", held);
        end
        wait_to(base + 7);
        checks++;
        if (held !== 4'b1100) begin
            failures++;
            $display("FAIL opp_held: got %b expected 1100", held);
        end
        wait_to(base + 12);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        wait_to(base + 18);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL opp_held_clear: got %b expected 0000", held);
        end
        wait_to(base + 20);
    endtask

    task automatic test_staggered_opposing();
        int base;
        base   = cyc;
        btn_up = 1'b1;
        push(base + 7, 4'b0001);
        push(base + 9, 4'b0010);
        wait_to(base + 2);
        btn_down = 1'b1;
        wait_to(base + 9);
        checks++;
        if (held !== 4'b0011) begin
            failures++;
            $display("FAIL stagger_held: got %b expected 0011", held);
        end
        wait_to(base + 12);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_to(base + 20);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL stagger_held_clear: got %b expected 0000", held);
        end
    endtask

    task automatic test_simultaneous();
        int base;
        base     = cyc;
        btn_up   = 1'b1;
        btn_left = 1'b1;
        push(base + 7, 4'b0101);
        wait_to(base + 7);
        checks++;
        if (held !== 4'b0101) begin
            failures++;
            $display("FAIL simul_held: got %b expected 0101", held);
        end
        wait_to(base + 12);
        btn_up   = 1'b0;
        btn_left = 1'b0;
        wait_to(base + 20);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL simul_held_clear: got %b expected 0000", held);
        end
    endtask

    task automatic test_release_bounce();
        int base;
        base   = cyc;
        btn_up = 1'b1;
        push(base + 7, 4'b0001);
        push(base + 17, 4'b0001);
        push(base + 20, 4'b0001);
        push(base + 28, 4'b0001);
        push(base + 31, 4'b0001);
        wait_to(base + 20);
        btn_up = 1'b0;
        wait_to(base + 22);
        btn_up = 1'b1;
        for (int k = 21; k <= 30; k++) begin
            wait_to(base + k);
            checks++;
            if (held !== 4'b0001) begin
                failures++;
                $display("FAIL bounce_held@%0d: got %b expected 0001", k, held);
            end
        end
        btn_up = 1'b0;
        wait_to(base + 35);
        checks++;
        if (held !== 4'b0001) begin
            failures++;
            $display("FAIL bounce_held_db: got %b expected 0001", held);
        end
        wait_to(base + 36);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL bounce_held_clear: got %b expected 0000", held);
        end
        wait_to(base + 40);
    endtask

    task automatic test_reset_mid_press();
        int base;
        base   = cyc;
        btn_up = 1'b1;
        wait_to(base + 5);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({held, right, left, down, up} !== 8'h00) begin
            failures++;
            $display("FAIL rst_press_outputs: got %b expected 00000000", {held, right, left, down, up});
        end
        wait_to(base + 9);
        rst  = 1'b1;
        base = cyc;
        push(base + 7, 4'b0001);
        wait_to(base + 6);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL rst_press_held_early: got %b expected 0000", held);
        end
        wait_to(base + 7);
        checks++;
        if (held !== 4'b0001) begin
            failures++;
            $display("FAIL rst_press_held: got %b expected 0001", held);
        end
        wait_to(base + 8);
        btn_up = 1'b0;
        wait_to(base + 16);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL rst_press_held_clear: got %b expected 0000", held);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int base;
        base   = cyc;
        btn_up = 1'b1;
        push(base + 7, 4'b0001);
        push(base + 17, 4'b0001);
        wait_to(base + 18);
        checks++;
        if (held !== 4'b0001) begin
            failures++;
            $display("FAIL rst_rpt_held_before: got %b expected 0001", held);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL rst_rpt_held_async: got %b expected 0000", held);
        end
        wait_to(base + 21);
        rst  = 1'b1;
        base = cyc;
        push(base + 7, 4'b0001);
        wait_to(base + 7);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({held, right, left, down, up} !== 8'h00) begin
            failures++;
            $display("FAIL rst_pulse_async: got %b expected 00000000", {held, right, left, down, up});
        end
        btn_up = 1'b0;
        wait_to(base + 10);
        rst = 1'b1;
        wait_to(base + 16);
        checks++;
        if (held !== 4'b0000) begin
            failures++;
            $display("FAIL rst_rpt_idle: got %b expected 0000", held);
        end
    endtask

    initial begin
        test_reset();
        test_press_repeat();
        test_glitch();
        test_opposing();
        test_staggered_opposing();
        test_simultaneous();
        test_release_bounce();
        test_reset_mid_press();
        test_reset_mid_repeat();
        wait_to(cyc + 4);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
